eca_seq_ctrl: RTL and testbench

ECA_SEQ_CTRL -- requirements
Module: eca_seq_ctrl

---
 rtl/eca_pkg.sv | 18 +
 rtl/eca_seq_ctrl_if.sv | 44 ++++
 rtl/eca_lat_cnt.sv | 30 +++
 rtl/eca_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_eca_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eca_pkg.sv
// Shared state encoding and default sizing for the erasure-code sequencing controller.
package eca_pkg;

    localparam int ECA_M_MAX      = 4;
    localparam int ECA_ENGINE_LAT = 3;
    localparam int ECA_CNT_W      = 16;
    localparam int ECA_ADDR_W     = $clog2(ECA_M_MAX);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        BM_RD   = 3'd2,
        BM_WAIT = 3'd3,
        COMPUTE = 3'd4,
        WRITE   = 3'd5
    } eca_state_t;

endpackage

// File: rtl/eca_seq_ctrl_if.sv
// Handshake bundle between the sequencer and its input buffer, bitmatrix memory,
// compute engine and output buffer.
interface eca_seq_ctrl_if #(
    parameter int BM_MEM_ADDR_W = eca_pkg::ECA_ADDR_W
);

    logic                     inbuf_empty;
    logic                     inbuf_rd_req;
    logic                     user_bm_mem_wr_req;
    logic                     bm_mem_rd_req;
    logic [BM_MEM_ADDR_W-1:0] bm_mem_rd_addr;
    logic                     bm_mem_rd_data_val;
    logic                     engine_load_bm;
    logic                     engine_en;
    logic                     outbuf_full;
    logic                     outbuf_wr_req;

    modport master (
        input  inbuf_empty,
        input  user_bm_mem_wr_req,
        input  bm_mem_rd_data_val,
        input  outbuf_full,
        output inbuf_rd_req,
        output bm_mem_rd_req,
        output bm_mem_rd_addr,
        output engine_load_bm,
        output engine_en,
        output outbuf_wr_req
    );

    modport slave (
        output inbuf_empty,
        output user_bm_mem_wr_req,
        output bm_mem_rd_data_val,
        output outbuf_full,
        input  inbuf_rd_req,
        input  bm_mem_rd_req,
        input  bm_mem_rd_addr,
        input  engine_load_bm,
        input  engine_en,
        input  outbuf_wr_req
    );

endinterface

// File: rtl/eca_lat_cnt.sv
// Engine latency counter: cleared on load, counts while enabled, flags the final
// compute cycle.
module eca_lat_cnt
    import eca_pkg::*;
#(
    parameter int ENGINE_LAT = ECA_ENGINE_LAT,
    parameter int LAT_W      = (ENGINE_LAT > 1) ? $clog2(ENGINE_LAT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + LAT_W'(1);
        end
    end

    assign done = (cnt == LAT_W'(ENGINE_LAT - 1));

endmodule

// File: rtl/eca_seq_ctrl.sv
// Per-stripe sequencer: pops one input stripe, then for each parity row reads the
// bitmatrix, runs the engine for ENGINE_LAT cycles and pushes one parity word.
module eca_seq_ctrl
    import eca_pkg::*;
#(
    parameter int M_MAX         = ECA_M_MAX,
    parameter int ENGINE_LAT    = ECA_ENGINE_LAT,
    parameter int M_W           = $clog2(M_MAX) + 1,
    parameter int BM_MEM_ADDR_W = $clog2(M_MAX),
    parameter int CNT_W         = ECA_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     eca_en,
    input  logic [M_W-1:0]           m_val,
    eca_seq_ctrl_if.master           bus,
    output logic                     busy,
    output logic [BM_MEM_ADDR_W-1:0] parity_idx,
    output logic                     stripe_done,
    output logic [CNT_W-1:0]         stripe_cnt,
    output logic                     cfg_err
);

    eca_state_t       state;
    eca_state_t       state_nxt;
    logic [M_W-1:0]   m_lat;
    logic             m_legal;
    logic             can_start;
    logic             last_row;
    logic             wr_fire;
    logic             start;
    logic             lat_load;
    logic             lat_done;

    assign m_legal   = (m_val != '0) && (m_val <= M_W'(M_MAX));
    assign can_start = eca_en && !bus.inbuf_empty && m_legal;
    assign last_row  = (M_W'(parity_idx) == (m_lat - M_W'(1)));
    assign wr_fire   = (state == WRITE) && !bus.outbuf_full;
    assign lat_load  = (state == BM_WAIT) && bus.bm_mem_rd_data_val;
    // A new stripe can begin from idle or straight off the last write of the previous one.
    assign start     = ((state == IDLE) || (wr_fire && last_row)) && can_start;

    eca_lat_cnt #(
        .ENGINE_LAT (ENGINE_LAT)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (lat_load),
        .en   (state == COMPUTE),
        .done (lat_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_start) state_nxt = FETCH;
            FETCH:   state_nxt = BM_RD;
            BM_RD:   if (!bus.user_bm_mem_wr_req) state_nxt = BM_WAIT;
            BM_WAIT: if (bus.bm_mem_rd_data_val) state_nxt = COMPUTE;
            COMPUTE: if (lat_done) state_nxt = WRITE;
            WRITE: begin
                if (!bus.outbuf_full) begin
                    if (!last_row) begin
                        state_nxt = BM_RD;
                    end else if (can_start) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // User writes to the bitmatrix memory always win over the controller's read.
    always_comb begin
        bus.inbuf_rd_req   = 1'b0;
        bus.bm_mem_rd_req  = 1'b0;
        bus.bm_mem_rd_addr = parity_idx;
        bus.engine_load_bm = 1'b0;
        bus.engine_en      = 1'b0;
        bus.outbuf_wr_req  = 1'b0;
        stripe_done        = 1'b0;
        busy               = (state != IDLE);
        case (state)
            FETCH:   bus.inbuf_rd_req   = 1'b1;
            BM_RD:   bus.bm_mem_rd_req  = !bus.user_bm_mem_wr_req;
            BM_WAIT: bus.engine_load_bm = bus.bm_mem_rd_data_val;
            COMPUTE: bus.engine_en      = 1'b1;
            WRITE: begin
                bus.outbuf_wr_req = !bus.outbuf_full;
                stripe_done       = !bus.outbuf_full && last_row;
            end
            default: ;
        endcase
    end

    // Row count is frozen at stripe start so later m_val changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_lat      <= '0;
            parity_idx <= '0;
            stripe_cnt <= '0;
            cfg_err    <= 1'b0;
        end else begin
            if (start) begin
                m_lat      <= m_val;
                parity_idx <= '0;
            end else if (wr_fire) begin
                parity_idx <= last_row ? '0 : parity_idx + BM_MEM_ADDR_W'(1);
            end
            if (wr_fire && last_row) begin
                stripe_cnt <= stripe_cnt + CNT_W'(1);
            end
            if (!eca_en) begin
                cfg_err <= 1'b0;
            end else if ((state == IDLE) && !m_legal) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eca_seq_ctrl.sv
// Directed bench for eca_seq_ctrl: single stripe, memory/output stalls, config
// errors, back-to-back stripes with enable drop, and reset mid-stripe.
module tb_eca_seq_ctrl;

    localparam int M_W   = 3;
    localparam int AW    = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             eca_en;
    logic [M_W-1:0]   m_val;
    logic             busy;
    logic [AW-1:0]    parity_idx;
    logic             stripe_done;
    logic [CNT_W-1:0] stripe_cnt;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;

    int n_fetch = 0, n_rd = 0, n_eng = 0, n_wr = 0, n_done = 0, n_excl = 0;
    int b_fetch, b_rd, b_eng, b_wr, b_done;

    eca_seq_ctrl_if #(.BM_MEM_ADDR_W(AW)) bus ();

    eca_seq_ctrl #(
        .M_MAX         (4),
        .ENGINE_LAT    (3),
        .M_W           (M_W),
        .BM_MEM_ADDR_W (AW),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .eca_en      (eca_en),
        .m_val       (m_val),
        .bus         (bus),
        .busy        (busy),
        .parity_idx  (parity_idx),
        .stripe_done (stripe_done),
        .stripe_cnt  (stripe_cnt),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    // Strobe tallies sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.inbuf_rd_req)   n_fetch++;
        if (bus.bm_mem_rd_req)  n_rd++;
        if (bus.engine_en)      n_eng++;
        if (bus.outbuf_wr_req)  n_wr++;
        if (stripe_done)        n_done++;
        if ($countones({bus.inbuf_rd_req, bus.bm_mem_rd_req, bus.outbuf_wr_req}) > 1) n_excl++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [M_W-1:0] m, input logic empty,
                                 input logic uwr, input logic val, input logic full);
        eca_en                 = en;
        m_val                  = m;
        bus.inbuf_empty        = empty;
        bus.user_bm_mem_wr_req = uwr;
        bus.bm_mem_rd_data_val = val;
        bus.outbuf_full        = full;
    endtask

    task automatic snap();
        b_fetch = n_fetch;
        b_rd    = n_rd;
        b_eng   = n_eng;
        b_wr    = n_wr;
        b_done  = n_done;
    endtask

    task automatic checkCounts(input string tag, input int fetch, input int rd, input int eng,
                               input int wr, input int done);
        checkOutput({tag, ".fetches"}, n_fetch - b_fetch, fetch);
        checkOutput({tag, ".reads"},   n_rd - b_rd,       rd);
        checkOutput({tag, ".eng_cyc"}, n_eng - b_eng,     eng);
        checkOutput({tag, ".writes"},  n_wr - b_wr,       wr);
        checkOutput({tag, ".dones"},   n_done - b_done,   done);
    endtask

    task automatic startStripe(input logic [M_W-1:0] m, input string tag);
        eca_en          = 1'b1;
        m_val           = m;
        bus.inbuf_empty = 1'b0;
        cyc();
        checkBit({tag, ".fetch"}, bus.inbuf_rd_req, 1'b1);
        checkBit({tag, ".busy"},  busy,             1'b1);
    endtask

    // One parity row from BM_RD through WRITE, optionally holding the output buffer full.
    task automatic runRow(input int addr, input logic last, input int full_cycles, input string tag);
        cyc();
        checkBit({tag, ".rd_req"},     bus.bm_mem_rd_req, 1'b1);
        checkOutput({tag, ".rd_addr"}, 32'(bus.bm_mem_rd_addr), addr);
        cyc();
        checkBit({tag, ".load_bm"}, bus.engine_load_bm, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            checkBit({tag, ".engine_en"}, bus.engine_en, 1'b1);
        end
        if (full_cycles > 0) begin
            bus.outbuf_full = 1'b1;
            for (int i = 0; i < full_cycles; i++) begin
                cyc();
                checkBit({tag, ".wr_while_full"}, bus.outbuf_wr_req, 1'b0);
                checkOutput({tag, ".idx_hold"},   32'(parity_idx),   addr);
            end
            bus.outbuf_full = 1'b0;
            #1;
        end else begin
            cyc();
        end
        checkBit({tag, ".wr_req"},      bus.outbuf_wr_req, 1'b1);
        checkBit({tag, ".eng_off"},     bus.engine_en,     1'b0);
        checkBit({tag, ".stripe_done"}, stripe_done,       last);
    endtask

    initial begin
        applyStimulus(1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;

        checkBit("rst.busy",          busy,              1'b0);
        checkOutput("rst.parity_idx", 32'(parity_idx),   0);
        checkOutput("rst.stripe_cnt", 32'(stripe_cnt),   0);
        checkBit("rst.cfg_err",       cfg_err,           1'b0);
        checkBit("rst.inbuf_rd",      bus.inbuf_rd_req,  1'b0);
        checkBit("rst.bm_rd",         bus.bm_mem_rd_req, 1'b0);
        checkBit("rst.engine_en",     bus.engine_en,     1'b0);
        checkBit("rst.outbuf_wr",     bus.outbuf_wr_req, 1'b0);
        checkBit("rst.stripe_done",   stripe_done,       1'b0);

        $display("[TB] single stripe, m_val=2");
        snap();
        startStripe(3'd2, "s1");
        bus.inbuf_empty = 1'b1;
        runRow(0, 1'b0, 0, "s1r0");
        runRow(1, 1'b1, 0, "s1r1");
        cyc();
        checkBit("s1.idle",          busy,            1'b0);
        checkOutput("s1.stripe_cnt", 32'(stripe_cnt), 1);
        checkCounts("s1", 1, 2, 6, 2, 1);

        $display("[TB] bitmatrix write stall and late read data, m_val=1");
        snap();
        bus.user_bm_mem_wr_req = 1'b1;
        startStripe(3'd1, "s2");
        bus.inbuf_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checkBit("s2.stall_rd", bus.bm_mem_rd_req, 1'b0);
            checkBit("s2.stall_busy", busy, 1'b1);
        end
        cyc();
        bus.user_bm_mem_wr_req = 1'b0;
        bus.bm_mem_rd_data_val = 1'b0;
        #1;
        checkBit("s2.rd_after_release", bus.bm_mem_rd_req, 1'b1);
        cyc();
        checkBit("s2.wait_noload", bus.engine_load_bm, 1'b0);
        checkBit("s2.wait_noeng",  bus.engine_en,      1'b0);
        cyc();
        checkBit("s2.wait_noload2", bus.engine_load_bm, 1'b0);
        bus.bm_mem_rd_data_val = 1'b1;
        #1;
        checkBit("s2.load_on_val", bus.engine_load_bm, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            checkBit("s2.engine_en", bus.engine_en, 1'b1);
        end
        cyc();
        checkBit("s2.wr_req",      bus.outbuf_wr_req, 1'b1);
        checkBit("s2.stripe_done", stripe_done,       1'b1);
        cyc();
        checkBit("s2.idle",          busy,            1'b0);
        checkOutput("s2.stripe_cnt", 32'(stripe_cnt), 2);
        checkCounts("s2", 1, 1, 3, 1, 1);

        $display("[TB] output buffer full for 4 cycles, m_val changed after latch");
        snap();
        startStripe(3'd2, "s3");
        bus.inbuf_empty = 1'b1;
        m_val = 3'd1;
        runRow(0, 1'b0, 4, "s3r0");
        runRow(1, 1'b1, 0, "s3r1");
        cyc();
        checkBit("s3.idle",          busy,            1'b0);
        checkOutput("s3.stripe_cnt", 32'(stripe_cnt), 3);
        checkCounts("s3", 1, 2, 6, 2, 1);

        $display("[TB] illegal m_val");
        bus.inbuf_empty = 1'b0;
        m_val = 3'd0;
        cyc();
        checkBit("cfg0.cfg_err",  cfg_err,          1'b1);
        checkBit("cfg0.busy",     busy,             1'b0);
        checkBit("cfg0.no_fetch", bus.inbuf_rd_req, 1'b0);
        m_val = 3'd5;
        cyc();
        checkBit("cfg5.cfg_err", cfg_err, 1'b1);
        checkBit("cfg5.busy",    busy,    1'b0);
        eca_en = 1'b0;
        cyc();
        checkBit("cfg.clear", cfg_err, 1'b0);
        checkBit("cfg.busy",  busy,    1'b0);

        $display("[TB] back-to-back stripes, m_val=4, enable dropped in stripe 2");
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checkOutput("rst2.stripe_cnt", 32'(stripe_cnt), 0);
        snap();
        startStripe(3'd4, "b1");
        for (int r = 0; r < 4; r++) runRow(r, (r == 3), 0, "b1row");
        cyc();
        checkBit("b2.fetch", bus.inbuf_rd_req, 1'b1);
        checkBit("b2.busy",  busy,             1'b1);
        eca_en = 1'b0;
        for (int r = 0; r < 4; r++) runRow(r, (r == 3), 0, "b2row");
        cyc();
        checkBit("b3.idle",          busy,            1'b0);
        checkOutput("b3.stripe_cnt", 32'(stripe_cnt), 2);
        repeat (3) cyc();
        checkBit("b3.still_idle", busy, 1'b0);
        checkCounts("b", 2, 8, 24, 8, 2);

        $display("[TB] reset during COMPUTE");
        startStripe(3'd2, "r1");
        bus.inbuf_empty = 1'b1;
        cyc();
        cyc();
        cyc();
        checkBit("r1.in_compute", bus.engine_en, 1'b1);
        rst = 1'b1;
        cyc();
        checkBit("r1.busy",          busy,              1'b0);
        checkBit("r1.engine_en",     bus.engine_en,     1'b0);
        checkOutput("r1.stripe_cnt", 32'(stripe_cnt),   0);
        checkBit("r1.outbuf_wr",     bus.outbuf_wr_req, 1'b0);
        checkOutput("r1.parity_idx", 32'(parity_idx),   0);
        snap();
        eca_en = 1'b0;
        rst = 1'b0;
        repeat (6) cyc();
        checkBit("r1.after_busy", busy, 1'b0);
        checkCounts("r1.after", 0, 0, 0, 0, 0);

        checkOutput("strobe_mutex", n_excl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
